muldiv_sequencer: RTL

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU that owns the HI/LO register pair. It runs one shift-and-add or restoring-subtract iteration per cycle over an internal 32-bit add/sub datapath. The block sits beside the EX-stage ALU. The pipeline starts an operation and reads results through HiOut and LoOut. The pipeline stalls MFHI/MFLO while Busy is high.

---
 rtl/muldiv_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
//                One shift-add (multiply) or restoring-subtract (divide)
//                step per cycle; WIDTH steps per operation.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_op;       // bit1: divide, bit0: signed
    logic                 r_qsign;    // product / quotient sign
    logic                 r_rsign;    // remainder sign
    logic                 r_dz;
    logic [WIDTH-1:0]     r_opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_upper;    // product upper half or remainder
    logic [WIDTH-1:0]     r_lower;    // multiplier/product lower or dividend/quotient
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_divzero;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_fits;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_upper_nx;
    logic [WIDTH-1:0]     w_lower_nx;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fx;
    logic                 w_neg_q;
    logic                 w_neg_r;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Start is honoured whenever no operation is running (IDLE or DONE)
    assign w_accept  = (r_state != S_RUN) && Start;
    assign w_divzero = Op[1] && (DataB == '0);
    assign w_last    = (r_state == S_RUN) && (r_cnt == c_LAST);

    // Operand magnitudes: signed ops iterate on absolute values
    assign w_mag_a = (Op[0] && DataA[WIDTH-1]) ? -DataA : DataA;
    assign w_mag_b = (Op[0] && DataB[WIDTH-1]) ? -DataB : DataB;

    // Multiply step: conditional add into the upper half with carry out
    assign w_mul_sum = r_lower[0] ? ({1'b0, r_upper} + {1'b0, r_opb}) : {1'b0, r_upper};

    // Divide step: shift {rem, quot} left, then trial-subtract the divisor
    assign w_rem_sh = {r_upper, r_lower[WIDTH-1]};
    assign w_fits   = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opb;

    assign w_upper_nx = r_op[1] ? (w_fits ? w_diff : w_rem_sh[WIDTH-1:0])
                                : w_mul_sum[WIDTH:1];
    assign w_lower_nx = r_op[1] ? {r_lower[WIDTH-2:0], w_fits}
                                : {w_mul_sum[0], r_lower[WIDTH-1:1]};

    // Sign fix-up applied to the final iteration's values at DONE entry
    assign w_neg_q   = r_op[0] && r_qsign;
    assign w_neg_r   = r_op[0] && r_rsign;
    assign w_prod    = {w_upper_nx, w_lower_nx};
    assign w_prod_fx = w_neg_q ? -w_prod : w_prod;
    assign w_res_hi  = r_op[1] ? (w_neg_r ? -w_upper_nx : w_upper_nx) : w_prod_fx[2*WIDTH-1:WIDTH];
    assign w_res_lo  = r_op[1] ? (w_neg_q ? -w_lower_nx : w_lower_nx) : w_prod_fx[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; a zero-divisor divide skips straight to DONE
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                if (Start) begin
                    w_state_nx = w_divzero ? S_DONE : S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
    end

    // Operand latch, iteration datapath and HI/LO register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_dz    <= 1'b0;
            r_opb   <= '0;
            r_upper <= '0;
            r_lower <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= Op;
            r_qsign <= DataA[WIDTH-1] ^ DataB[WIDTH-1];
            r_rsign <= DataA[WIDTH-1];
            r_dz    <= w_divzero;
            r_opb   <= Op[1] ? w_mag_b : w_mag_a;
            r_lower <= Op[1] ? w_mag_a : w_mag_b;
            r_upper <= '0;
            if (w_divzero) begin
                r_hi <= DataA;
                r_lo <= '1;
            end
        end else if (r_state == S_RUN) begin
            r_upper <= w_upper_nx;
            r_lower <= w_lower_nx;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else begin
            if (HiWrite) begin
                r_hi <= DataA;
            end
            if (LoWrite) begin
                r_lo <= DataA;
            end
        end
    end

    assign Busy    = (r_state == S_RUN);
    assign Done    = (r_state == S_DONE);
    assign DivZero = (r_state == S_DONE) && r_dz;
    assign HiOut   = r_hi;
    assign LoOut   = r_lo;

endmodule
`default_nettype wire
